pipe_carryadd: RTL and testbench

PIPE_CARRYADD -- requirements
Module: pipe_carryadd

---
 rtl/carryadd_pkg.sv | 13 +
 rtl/carryadd_slice.sv | 27 ++
 rtl/pipe_carryadd.sv | 118 +++++++++++
 tb/tb_pipe_carryadd.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/carryadd_pkg.sv
// Shared definitions for the pipelined carry adder: mode encoding and a
// parameter legality check used at elaboration.
package carryadd_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // True when the operand width splits evenly into non-empty pipeline chunks.
   function automatic bit params_ok(input int unsigned width, input int unsigned stages);
      return (width != 0) && (stages != 0) && (stages <= width) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/carryadd_slice.sv
// Combinational ripple adder for one pipeline chunk; also exposes the carry
// into its top bit so the final stage can form signed overflow.
module carryadd_slice #(
   parameter int unsigned W = 2
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co,
   output logic         c_msb_in
);

   always_comb begin
      logic [W:0] c;
      s    = '0;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < W; i++) begin
         s[i]     = a[i] ^ b[i] ^ c[i];
         c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      co       = c[W];
      c_msb_in = c[W - 1];
   end

endmodule

// File: rtl/pipe_carryadd.sv
// Staggered pipelined adder/subtractor: each stage resolves one CHUNK of the
// sum and forwards its carry plus the not-yet-consumed operand bits.
module pipe_carryadd
   import carryadd_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned CHUNK = (STAGES == 0) ? WIDTH : WIDTH / STAGES;

   if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
      $fatal(1, "pipe_carryadd: WIDTH=%0d is not a non-zero multiple of STAGES=%0d", WIDTH, STAGES);
   end

   // Whole pipeline advances together unless the output is held by the consumer.
   logic en;
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int unsigned IN_W  = WIDTH - k * CHUNK;
      localparam int unsigned SUM_W = (k + 1) * CHUNK;

      logic [IN_W-1:0]  a_in;
      logic [IN_W-1:0]  b_in;
      logic             ci;
      logic             vld_in;
      logic             vld;
      logic [CHUNK-1:0] s;
      logic             co;
      logic             c_msb;
      logic [SUM_W-1:0] sum_d;

      if (k == 0) begin : g_first
         // Subtraction is a + ~b + 1: invert b once here, force the carry-in.
         assign a_in   = a;
         assign b_in   = (mode == MODE_SUB) ? ~b : b;
         assign ci     = (mode == MODE_SUB) ? 1'b1 : cin;
         assign vld_in = in_valid;
         assign sum_d  = s;
      end else begin : g_next
         assign a_in   = g_stg[k-1].g_mid.a_q;
         assign b_in   = g_stg[k-1].g_mid.b_q;
         assign ci     = g_stg[k-1].g_mid.c_q;
         assign vld_in = g_stg[k-1].vld;
         assign sum_d  = {s, g_stg[k-1].g_mid.sum_q};
      end

      carryadd_slice #(
         .W (CHUNK)
      ) u_slice (
         .a        (a_in[CHUNK-1:0]),
         .b        (b_in[CHUNK-1:0]),
         .ci       (ci),
         .s        (s),
         .co       (co),
         .c_msb_in (c_msb)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld <= 1'b0;
         end else if (en) begin
            vld <= vld_in;
         end
      end

      if (k < STAGES - 1) begin : g_mid
         logic [IN_W-CHUNK-1:0] a_q;
         logic [IN_W-CHUNK-1:0] b_q;
         logic                  c_q;
         logic [SUM_W-1:0]      sum_q;
         logic                  unused_c_msb;

         assign unused_c_msb = c_msb;

         // Bubbles leave the data registers untouched.
         always_ff @(posedge clk) begin
            if (en && vld_in) begin
               a_q   <= a_in[IN_W-1:CHUNK];
               b_q   <= b_in[IN_W-1:CHUNK];
               c_q   <= co;
               sum_q <= sum_d;
            end
         end
      end else begin : g_last
         assign out_valid = vld;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               y    <= '0;
               cout <= 1'b0;
               ovf  <= 1'b0;
            end else if (en && vld_in) begin
               y    <= sum_d;
               cout <= co;
               ovf  <= co ^ c_msb;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipe_carryadd.sv
// Scoreboard bench for pipe_carryadd: three configurations run side by side,
// each with directed, random-stall and reset-in-flight phases.
module tb_pipe_carryadd;
   import carryadd_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      logic       m;
      logic [7:0] y;
      logic       co;
      logic       ov;
   } dir_t;

   localparam int NCFG = 3;
   bit done [NCFG];

   for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
      localparam int unsigned W = (gi == 0) ? 8 : 32;
      localparam int unsigned S = (gi == 0) ? 4 : ((gi == 1) ? 8 : 1);
      localparam int NOPS = (gi == 0) ? 16 : 200;

      typedef struct packed {
         logic [W-1:0] y;
         logic         c;
         logic         v;
      } exp_t;

      logic         rst_n     = 1'b1;
      logic         in_valid  = 1'b0;
      logic         in_ready;
      logic         cin       = 1'b0;
      logic         mode      = 1'b0;
      logic         out_valid;
      logic         out_ready = 1'b1;
      logic         cout;
      logic         ovf;
      logic [W-1:0] a = '0;
      logic [W-1:0] b = '0;
      logic [W-1:0] y;
      exp_t         q[$];
      dir_t         dir[7];

      pipe_carryadd #(
         .WIDTH  (W),
         .STAGES (S)
      ) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .a         (a),
         .b         (b),
         .cin       (cin),
         .mode      (mode),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .y         (y),
         .cout      (cout),
         .ovf       (ovf)
      );

      // Reference: unsigned arithmetic for y/cout, signed range test for ovf.
      function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] z,
                                     input logic c, input logic m);
         exp_t   e;
         longint ux, uz, sx, sz, r, u, lim;
         ux  = longint'(x);
         uz  = longint'(z);
         sx  = longint'($signed(x));
         sz  = longint'($signed(z));
         lim = longint'(1) <<< (W - 1);
         if (m == MODE_SUB) begin
            u   = ux - uz;
            e.c = (ux >= uz);
            r   = sx - sz;
         end else begin
            u   = ux + uz + longint'(c);
            e.c = (u >= (longint'(1) <<< W));
            r   = sx + sz + longint'(c);
         end
         e.y = W'(u);
         e.v = (r >= lim) || (r < -lim);
         return e;
      endfunction

      function automatic exp_t dir_exp(input dir_t d);
         exp_t e;
         if (W == 8) begin
            e.y = W'(d.y);
            e.c = d.co;
            e.v = d.ov;
         end else begin
            e = model(W'(d.a), W'(d.b), d.c, d.m);
         end
         return e;
      endfunction

      task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL cfg%0d %s: got %h want %h", gi, name, got, want);
         end
      endtask

      task automatic check_exp(input string name, input exp_t got, input exp_t want);
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL cfg%0d %s: got y=%h c=%b v=%b want y=%h c=%b v=%b",
                     gi, name, got.y, got.c, got.v, want.y, want.c, want.v);
         end
      endtask

      task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                           input logic tc, input logic tm, input exp_t e);
         int g;
         a        = ta;
         b        = tb2;
         cin      = tc;
         mode     = tm;
         in_valid = 1'b1;
         #1;
         g = 0;
         while (!in_ready && g < 100) begin
            @(negedge clk);
            #1;
            g++;
         end
         check_val("accept", 64'(in_ready), 64'(1));
         if (in_ready) q.push_back(e);
         @(negedge clk);
         in_valid = 1'b0;
      endtask

      task automatic drain();
         int g;
         in_valid  = 1'b0;
         out_ready = 1'b1;
         g = 0;
         while (q.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
         end
         check_val("drain", 64'(q.size()), 64'(0));
      endtask

      // Monitor: pops on every transfer and checks hold-stability on stalls.
      initial begin
         bit   stalled;
         exp_t held;
         exp_t got;
         stalled = 1'b0;
         held    = '0;
         forever begin
            @(negedge clk);
            #2;
            if (rst_n !== 1'b1) begin
               stalled = 1'b0;
               continue;
            end
            got = {y, cout, ovf};
            check_val("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            if (stalled) begin
               total++;
               if (out_valid !== 1'b1 || got !== held) begin
                  bad++;
                  $display("FAIL cfg%0d stall_hold: got v=%b y=%h want v=1 y=%h",
                           gi, out_valid, got.y, held.y);
               end
            end
            if (out_valid === 1'b1 && out_ready) begin
               if (q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL cfg%0d unexpected_output: got y=%h want none", gi, y);
               end else begin
                  check_exp("result", got, q.pop_front());
               end
            end
            stalled = (out_valid === 1'b1) && !out_ready;
            held    = got;
         end
      end

      // Driver.
      initial begin
         int lat;
         int n;
         dir[0] = '{8'd200,  8'd55,  1'b0, MODE_ADD, 8'd255,  1'b0, 1'b0};
         dir[1] = '{8'd200,  8'd100, 1'b0, MODE_ADD, 8'd44,   1'b1, 1'b0};
         dir[2] = '{8'd127,  8'd1,   1'b0, MODE_ADD, 8'd128,  1'b0, 1'b1};
         dir[3] = '{8'd5,    8'd7,   1'b0, MODE_SUB, 8'd254,  1'b0, 1'b0};
         dir[4] = '{8'h80,   8'd1,   1'b0, MODE_SUB, 8'h7F,   1'b1, 1'b1};
         dir[5] = '{8'd255,  8'd0,   1'b1, MODE_ADD, 8'd0,    1'b1, 1'b0};
         dir[6] = '{8'd10,   8'd3,   1'b1, MODE_SUB, 8'd7,    1'b1, 1'b0};

         #1 rst_n = 1'b0;
         repeat (2) @(negedge clk);
         #1;
         check_val("reset_state", 64'({out_valid, y, cout, ovf, in_ready}),
                   64'({1'b0, W'(0), 1'b0, 1'b0, 1'b1}));
         @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);

         // First op into an empty pipe: count sample points until out_valid.
         issue(W'(dir[0].a), W'(dir[0].b), dir[0].c, dir[0].m, dir_exp(dir[0]));
         lat = 1;
         #1;
         while (out_valid !== 1'b1 && lat < 4 * S + 8) begin
            @(negedge clk);
            #1;
            lat++;
         end
         check_val("latency", 64'(lat), 64'(S));
         @(negedge clk);

         for (int k = 1; k < 7; k++)
            issue(W'(dir[k].a), W'(dir[k].b), dir[k].c, dir[k].m, dir_exp(dir[k]));
         drain();

         // Random stream with bubbles and consumer back-pressure.
         n = 0;
         while (n < NOPS) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 4) != 0);
            a         = W'($urandom);
            b         = W'($urandom);
            cin       = 1'($urandom_range(0, 1));
            mode      = 1'($urandom_range(0, 1));
            #1;
            if (in_valid && in_ready) begin
               q.push_back(model(a, b, cin, mode));
               n++;
            end
            @(negedge clk);
         end
         drain();

         // Reset with operations still in flight.
         out_ready = 1'b1;
         for (int k = 0; k < 3; k++) begin
            a = W'($urandom);
            b = W'($urandom);
            issue(a, b, 1'b0, MODE_ADD, model(a, b, 1'b0, MODE_ADD));
         end
         #3 rst_n = 1'b0;
         #1;
         check_val("reset_midflight", 64'({out_valid, y, cout, ovf, in_ready}),
                   64'({1'b0, W'(0), 1'b0, 1'b0, 1'b1}));
         q.delete();
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         repeat (2 * S + 6) @(negedge clk);
         #1;
         check_val("post_reset_idle", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
         done[gi] = 1'b1;
      end
   end

   initial begin
      int t;
      t = 0;
      while (!(done[0] && done[1] && done[2]) && t < 20000) begin
         @(negedge clk);
         t++;
      end
      if (!(done[0] && done[1] && done[2])) begin
         total++;
         bad++;
         $display("FAIL timeout: got done=%b%b%b want 111", done[0], done[1], done[2]);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
